// File: rtl/counter_sequencer_if.sv
// Bundle of the sequencer's configuration, control and counter-side signals.
// slave  : the sequencer itself (consumes config/control and the counter's
//          q/min_tick, drives the counter controls and status).
// master : whoever programs the sequencer together with the external counter.
//
// Signals:
//   cfg_we, cfg_period[N], cfg_mode[2], cfg_prescale[P]  configuration write
//   start, stop, irq_clr                                  control requests
//   cnt_q[N], cnt_min_tick                                counter feedback
//   cnt_syn_clr, cnt_load, cnt_en, cnt_up, cnt_d[N]       counter controls
//   busy, done, irq                                       status
interface counter_sequencer_if #(
    parameter int N = 8,
    parameter int P = 4
);
    logic         cfg_we;
    logic [N-1:0] cfg_period;
    logic [1:0]   cfg_mode;
    logic [P-1:0] cfg_prescale;
    logic         start;
    logic         stop;
    logic         irq_clr;
    logic [N-1:0] cnt_q;
    logic         cnt_min_tick;
    logic         cnt_syn_clr;
    logic         cnt_load;
    logic         cnt_en;
    logic         cnt_up;
    logic [N-1:0] cnt_d;
    logic         busy;
    logic         done;
    logic         irq;

    modport master (
        output cfg_we, cfg_period, cfg_mode, cfg_prescale,
        output start, stop, irq_clr,
        output cnt_q, cnt_min_tick,
        input  cnt_syn_clr, cnt_load, cnt_en, cnt_up, cnt_d,
        input  busy, done, irq
    );

    modport slave (
        input  cfg_we, cfg_period, cfg_mode, cfg_prescale,
        input  start, stop, irq_clr,
        input  cnt_q, cnt_min_tick,
        output cnt_syn_clr, cnt_load, cnt_en, cnt_up, cnt_d,
        output busy, done, irq
    );
endinterface

// File: rtl/counter_sequencer.sv
// Interval-timing sequencer for an external N-bit up/down counter.
// Owns the counter's clear/load/enable/direction/data inputs, adds a
// prescaler, a small config register set, per-expiry done pulses and a
// sticky irq flag.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    counter_sequencer_if.slave (config, control, counter, status)
//
// state | meaning
// IDLE  | waiting for start; config writes accepted; counter untouched
// LOAD  | one cycle: load period (down) or clear counter (up)
// RUN   | prescaled counting; expiry on terminal tick
module counter_sequencer #(
    parameter int N = 8,
    parameter int P = 4
) (
    input logic                  clk,
    input logic                  reset,
    counter_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] period_reg;
    logic [1:0]   mode_reg;
    logic [P-1:0] prescale_reg;
    logic [P-1:0] pre_cnt;
    logic         irq_reg;

    logic periodic;
    logic up;
    logic tick;
    logic terminal;
    logic expiry;
    logic reload;

    assign periodic = mode_reg[0];
    assign up       = mode_reg[1];
    assign tick     = (state == RUN) && (pre_cnt == prescale_reg);
    assign terminal = up ? (bus.cnt_q == period_reg) : bus.cnt_min_tick;
    assign expiry   = tick && terminal;
    // A stop on the expiry cycle ends the run, so the counter is not re-armed.
    assign reload   = expiry && periodic && !bus.stop;

    assign bus.cnt_load    = ((state == LOAD) && !up) || (reload && !up);
    assign bus.cnt_syn_clr = ((state == LOAD) && up)  || (reload && up);
    // stop freezes the counter value on the cycle it is seen.
    assign bus.cnt_en      = tick && !terminal && !bus.stop;
    assign bus.cnt_up      = up;
    assign bus.cnt_d       = period_reg;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = expiry;
    assign bus.irq         = irq_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            period_reg   <= '0;
            mode_reg     <= '0;
            prescale_reg <= '0;
            pre_cnt      <= '0;
            irq_reg      <= 1'b0;
        end else begin
            // Set has priority over clear.
            if (expiry) begin
                irq_reg <= 1'b1;
            end else if (bus.irq_clr) begin
                irq_reg <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.cfg_we) begin
                        period_reg   <= bus.cfg_period;
                        mode_reg     <= bus.cfg_mode;
                        prescale_reg <= bus.cfg_prescale;
                    end
                    if (bus.start && !bus.stop) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    pre_cnt <= '0;
                    state   <= bus.stop ? IDLE : RUN;
                end
                RUN: begin
                    pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                    if (bus.stop || (expiry && !periodic)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: models the external universal counter and
// predicts every run from interval arithmetic on (period, prescale, mode).
module tb_counter_sequencer;
    localparam int N = 8;
    localparam int P = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    counter_sequencer_if #(.N(N), .P(P)) bus();
    counter_sequencer #(.N(N), .P(P)) dut (.clk(clk), .reset(reset), .bus(bus));

    // External counter driven by the sequencer.
    logic [N-1:0] q = '0;
    always @(posedge clk) begin
        if (bus.cnt_syn_clr)   q <= '0;
        else if (bus.cnt_load) q <= bus.cnt_d;
        else if (bus.cnt_en)   q <= bus.cnt_up ? q + 1'b1 : q - 1'b1;
    end
    assign bus.cnt_q        = q;
    assign bus.cnt_min_tick = (q == '0);

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cfg_we  = 1'b0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.irq_clr = 1'b0;
    endtask

    task automatic program_start(input int p, input int s, input logic [1:0] m);
        bus.cfg_we       = 1'b1;
        bus.cfg_period   = p[N-1:0];
        bus.cfg_mode     = m;
        bus.cfg_prescale = s[P-1:0];
        bus.start        = 1'b1;
        bus.irq_clr      = 1'b1;
    endtask

    // One full run checked cycle by cycle. Called at posedge+1 in IDLE.
    task automatic run_model(input int p, input int s, input logic [1:0] m);
        int  len, cmax, r, ri, eq;
        logic up, per, eb, ed, el, ec, ee, ei, tk, cq;
        len = (p + 1) * (s + 1);
        up  = m[1];
        per = m[0];
        program_start(p, s, m);
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        next();
        idle_inputs();
        cmax = per ? 2 + 2 * len : 2 + len;
        for (int c = 1; c <= cmax; c++) begin
            @(negedge clk);
            r  = c - 2;
            cq = 1'b1;
            eq = 0;
            if (c == 1) begin
                eb = 1; ed = 0; el = !up; ec = up; ee = 0; ei = 0; cq = 1'b0;
            end else if (!per && r >= len) begin
                eb = 0; ed = 0; el = 0; ec = 0; ee = 0; ei = 1;
                eq = up ? p : 0;
            end else begin
                ri = r % len;
                ed = (ri == len - 1);
                tk = ((r % (s + 1)) == s);
                eq = up ? ri / (s + 1) : p - ri / (s + 1);
                ee = tk && !ed;
                el = ed && per && !up;
                ec = ed && per && up;
                ei = (r >= len);
                eb = 1;
            end
            chk("busy", bus.busy, eb);
            chk("done", bus.done, ed);
            chk("cnt_load", bus.cnt_load, el);
            chk("cnt_syn_clr", bus.cnt_syn_clr, ec);
            chk("cnt_en", bus.cnt_en, ee);
            chk("irq", bus.irq, ei);
            if (cq) chk("cnt_q", bus.cnt_q, eq);
            next();
        end
        if (per) begin
            bus.stop = 1'b1;
            next();
            bus.stop = 1'b0;
            @(negedge clk);
            chk("stop_busy", bus.busy, 0);
            next();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, done_cnt, pr, sr;
        logic [1:0] mr;
        reset = 1'b1;
        idle_inputs();
        bus.cfg_period   = '0;
        bus.cfg_mode     = '0;
        bus.cfg_prescale = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_irq", bus.irq, 0);
        chk("rst_cnt_d", bus.cnt_d, 0);
        chk("rst_cnt_up", bus.cnt_up, 0);
        chk("rst_ctrl", {bus.cnt_load, bus.cnt_syn_clr, bus.cnt_en}, 0);
        next();

        // Directed interval shapes, then randomized ones.
        run_model(3, 0, 2'b00);
        run_model(2, 1, 2'b11);
        run_model(0, 0, 2'b01);
        run_model(255, 0, 2'b10);
        for (int k = 0; k < 12; k++) begin
            pr = $urandom_range(0, 6);
            sr = $urandom_range(0, 3);
            mr = 2'($urandom_range(0, 3));
            run_model(pr, sr, mr);
        end

        // Mid-run stop at q=5, then reprogram while starting.
        program_start(9, 0, 2'b00);
        next();
        idle_inputs();
        for (int i = 0; i < 30 && bus.cnt_q != 5; i++) next();
        chk("reach_q5", bus.cnt_q, 5);
        bus.stop = 1'b1;
        @(negedge clk);
        chk("stop_done", bus.done, 0);
        chk("stop_en", bus.cnt_en, 0);
        next();
        bus.stop = 1'b0;
        @(negedge clk);
        chk("stop_idle", bus.busy, 0);
        chk("stop_q_held", bus.cnt_q, 5);
        chk("stop_irq", bus.irq, 0);
        next();
        bus.cfg_we     = 1'b1;
        bus.cfg_period = 8'd1;
        bus.start      = 1'b1;
        next();
        idle_inputs();
        @(negedge clk);
        chk("reprog_load", bus.cnt_load, 1);
        chk("reprog_d", bus.cnt_d, 1);
        repeat (5) next();

        // irq set/clear priority; cfg write ignored while busy.
        program_start(1, 0, 2'b01);
        next();
        idle_inputs();
        next();
        bus.cfg_we     = 1'b1;
        bus.cfg_period = 8'd7;
        next();
        bus.cfg_we  = 1'b0;
        bus.irq_clr = 1'b1;
        @(negedge clk);
        chk("exp_done", bus.done, 1);
        chk("cfg_ignored", bus.cnt_d, 1);
        next();
        @(negedge clk);
        chk("irq_set_wins", bus.irq, 1);
        next();
        bus.irq_clr = 1'b0;
        @(negedge clk);
        chk("irq_cleared", bus.irq, 0);
        bus.stop = 1'b1;
        next();
        bus.stop = 1'b0;
        next();

        // start while busy does not lengthen a one-shot interval.
        program_start(4, 1, 2'b00);
        next();
        idle_inputs();
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            bus.start = (i == 4);
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            next();
        end
        bus.start = 1'b0;
        chk("busy_len", busy_cnt, 11);
        chk("done_count", done_cnt, 1);
        chk("oneshot_q_end", bus.cnt_q, 0);

        // stop wins over start in IDLE.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        next();
        idle_inputs();
        @(negedge clk);
        chk("stop_beats_start", bus.busy, 0);
        next();

        // Async reset between edges mid-run.
        program_start(3, 0, 2'b01);
        next();
        idle_inputs();
        repeat (7) next();
        chk("pre_rst_irq", bus.irq, 1);
        chk("pre_rst_busy", bus.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_irq", bus.irq, 0);
        chk("arst_ctrl", {bus.cnt_load, bus.cnt_syn_clr, bus.cnt_en}, 0);
        chk("arst_cnt_d", bus.cnt_d, 0);
        @(negedge clk);
        reset = 1'b0;
        next();
        @(negedge clk);
        chk("post_rst_cnt_d", bus.cnt_d, 0);
        chk("post_rst_busy", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
